// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, request arbitration and mtc0/mfc0/eret access.
// Optional CP0_COUNT_EN adds the free-running Count register at CP0 reg 9.
module cp0_exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] ADDR_COUNT = 5'd9;
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic w_int_req;
  logic w_exc_req;
  logic w_wr_ok;

  assign w_int_req = r_ie & ~r_exl & (|(hw_int & r_im));
  assign w_exc_req = ~r_exl & (exc_code_in != 5'd0);
  assign req       = (w_int_req | w_exc_req) & ~reset;
  assign epc_out   = r_epc;
  // A taken request cancels the M-stage instruction, so its mtc0 is dropped.
  assign w_wr_ok   = we & ~req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= hw_int;
      if (req) begin
        r_exl      <= 1'b1;
        r_bd       <= bd_in;
        r_exc_code <= w_int_req ? 5'd0 : exc_code_in;
        r_epc      <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (w_wr_ok) begin
          case (cp0_addr)
            ADDR_SR: begin
              r_im  <= cp0_in[15:10];
              r_exl <= cp0_in[1];
              r_ie  <= cp0_in[0];
            end
            ADDR_EPC: r_epc <= cp0_in;
            default: ;
          endcase
        end
        // eret after the SR write: the later assignment forces EXL low.
        if (exl_clr) r_exl <= 1'b0;
      end
    end
  end

`ifdef CP0_COUNT_EN
  logic [31:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_ok && (cp0_addr == ADDR_COUNT)) begin
      r_count <= cp0_in;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end
`endif

  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      ADDR_SR:    cp0_out = {16'd0, r_im, 8'd0, r_exl, r_ie};
      ADDR_CAUSE: cp0_out = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
      ADDR_EPC:   cp0_out = r_epc;
`ifdef CP0_COUNT_EN
      ADDR_COUNT: cp0_out = r_count;
`endif
      default:    cp0_out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed-vector bench for cp0_exc_ctrl; expected values are hand-computed constants.
`timescale 1ns/100ps
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] cp0_out;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] epc_out;
  logic        req;

  int unsigned n_vec;
  int unsigned n_err;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .cp0_addr   (cp0_addr),
    .cp0_in     (cp0_in),
    .cp0_out    (cp0_out),
    .vpc        (vpc),
    .bd_in      (bd_in),
    .exc_code_in(exc_code_in),
    .hw_int     (hw_int),
    .exl_clr    (exl_clr),
    .epc_out    (epc_out),
    .req        (req)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_out, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, req}, {31'd0, exp});
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    we = 1'b1; cp0_addr = addr; cp0_in = data;
    tick();
    we = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; we = 1'b0; cp0_addr = '0; cp0_in = '0; vpc = '0;
    bd_in = 1'b0; exc_code_in = '0; hw_int = '0; exl_clr = 1'b0;
    #3;
    exc_code_in = 5'd4;
    chk_req("rst_req", 1'b0);
    exc_code_in = '0;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    tick(); tick();
    reset = 1'b0;

    // synchronous exception, not in delay slot
    exc_code_in = 5'd4; vpc = 32'h3008; bd_in = 1'b0;
    chk_req("exc_req", 1'b1);
    tick();
    chk_req("exc_req_exl", 1'b0);
    exc_code_in = '0;
    rd("exc_sr", 5'd12, 32'h0000_0002);
    rd("exc_cause", 5'd13, 32'h0000_0010);
    rd("exc_epc", 5'd14, 32'h3008);
    chk("exc_epc_out", epc_out, 32'h3008);
    exl_clr = 1'b1; tick(); exl_clr = 1'b0;
    rd("eret_sr", 5'd12, 32'h0);

    // interrupt from delay slot
    wr(5'd12, 32'h0000_0401);
    rd("sr_wr", 5'd12, 32'h0000_0401);
    hw_int = 6'b000001; bd_in = 1'b1; vpc = 32'h3010;
    chk_req("int_req", 1'b1);
    tick();
    bd_in = 1'b0;
    chk_req("int_req_exl", 1'b0);
    rd("int_cause", 5'd13, 32'h8000_0400);
    chk("int_epc", epc_out, 32'h300C);

    // eret with interrupt pending: no req this cycle, req next cycle
    exl_clr = 1'b1;
    chk_req("eret_pend_req", 1'b0);
    tick();
    exl_clr = 1'b0;
    rd("eret_pend_sr", 5'd12, 32'h0000_0401);
    chk_req("pend_req", 1'b1);

    // interrupt beats exception; concurrent mtc0 to EPC discarded
    exc_code_in = 5'd12; vpc = 32'h3020; we = 1'b1; cp0_addr = 5'd14; cp0_in = 32'hDEAD;
    tick();
    we = 1'b0; exc_code_in = '0; hw_int = '0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    chk("prio_epc", epc_out, 32'h3020);
    rd("prio_sr", 5'd12, 32'h0000_0403);

    // req together with eret: EXL stays set
    exl_clr = 1'b1; tick(); exl_clr = 1'b0;
    exc_code_in = 5'd8; exl_clr = 1'b1; vpc = 32'h4000;
    chk_req("req_eret", 1'b1);
    tick();
    exc_code_in = '0; exl_clr = 1'b0;
    rd("req_eret_sr", 5'd12, 32'h0000_0403);
    rd("req_eret_cause", 5'd13, 32'h0000_0020);
    chk("req_eret_epc", epc_out, 32'h4000);

    // SR write with eret: write applied, EXL forced low
    we = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_FC03; exl_clr = 1'b1;
    tick();
    we = 1'b0; exl_clr = 1'b0;
    rd("wr_eret_sr", 5'd12, 32'h0000_FC01);

    // Cause is read-only, SR masks unimplemented bits
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0000_0020);
    wr(5'd12, 32'hFFFF_FFFF);
    rd("sr_mask", 5'd12, 32'h0000_FC03);
    exl_clr = 1'b1; tick(); exl_clr = 1'b0;

    // EPC write and delay-slot wrap at PC 0
    wr(5'd14, 32'h1234_5678);
    rd("epc_wr", 5'd14, 32'h1234_5678);
    exc_code_in = 5'd5; vpc = 32'h0; bd_in = 1'b1;
    tick();
    exc_code_in = '0; bd_in = 1'b0;
    chk("epc_wrap", epc_out, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0014);
    rd("unimpl_addr", 5'd3, 32'h0);
    exl_clr = 1'b1; tick(); exl_clr = 1'b0;

    // masking: IM bit clear, then IE clear
    wr(5'd12, 32'h0000_0401);
    hw_int = 6'b000010;
    chk_req("im_mask", 1'b0);
    wr(5'd12, 32'h0000_FC00);
    chk_req("ie_mask", 1'b0);
    hw_int = '0;
    wr(5'd12, 32'h0000_FC01);

    // Count register
    wr(5'd9, 32'hFFFF_FFFE);
`ifdef CP0_COUNT_EN
    tick();
    rd("count_ff", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("count_wrap", 5'd9, 32'h0);
`else
    rd("count_absent", 5'd9, 32'h0);
`endif

    // asynchronous reset mid-operation
    hw_int = 6'b000010;
    chk_req("pre_rst_req", 1'b1);
    reset = 1'b1;
    chk_req("mid_rst_req", 1'b0);
    rd("mid_rst_sr", 5'd12, 32'h0);
    rd("mid_rst_cause", 5'd13, 32'h0);
    chk("mid_rst_epc", epc_out, 32'h0);
    rd("mid_rst_count", 5'd9, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception and interrupt controller for the P7 pipelined MIPS core. It sits at the M stage and consumes the exception-carrying fields of the E/M pipeline register: `pc_M`, `BDIn_M` and `excCode_M`. It also takes the six external hardware interrupt lines. It holds SR, Cause and EPC, arbitrates interrupts against synchronous exceptions, and raises `req` to flush the pipeline and redirect fetch to the handler. It also serves `mtc0`/`mfc0`/`eret` accesses issued from the M stage.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all CP0 state immediately.
- `we`  in  1  `mtc0` write strobe (M stage).
- `cp0_addr`  in  5  CP0 register number for read and write.
- `cp0_in`  in  32  `mtc0` write data.
- `cp0_out`  out  32  `mfc0` read data; combinational from `cp0_addr`.
- `vpc`  in  32  PC of the M-stage instruction (`pc_M`).
- `bd_in`  in  1  M-stage instruction is in a delay slot (`BDIn_M`).
- `exc_code_in`  in  5  pending synchronous exception code; 0 = none (`excCode_M`).
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `exl_clr`  in  1  `eret` in M stage.
- `epc_out`  out  32  current EPC register value.
- `req`  out  1  take exception/interrupt this cycle; combinational.

## Operation
- SR (reg 12):
  - Implemented fields: IM[15:10], EXL[1], IE[0].
  - Other bits read 0.
  - `mtc0` writes only the implemented bits.
- Cause (reg 13):
  - Fields: BD[31], IP[15:10], ExcCode[6:2].
  - Other bits read 0.
  - Read-only to `mtc0`; writes are ignored.
- EPC (reg 14): 32-bit, fully writable by `mtc0`.
- Reads of any other address return 0.
- Request logic:
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (exc_code_in != 0).
  - req = (int_req | exc_req) & ~reset.
- Priority: interrupt beats synchronous exception.
- On a rising edge with req=1:
  - EXL <= 1.
  - BD <= bd_in.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - EPC <= bd_in ? vpc-4 : vpc (32-bit modular subtract).
- IP <= hw_int on every edge, unconditionally, including req cycles.
- `exl_clr` with req=0 clears EXL at the edge.
- Simultaneous events:
  - req=1 together with `we`: the write is discarded, because the M-stage instruction is cancelled.
  - req=1 together with `exl_clr`: req wins and EXL stays 1.
  - `we` to SR together with `exl_clr`: apply the write first, then force EXL=0.
- When EXL=1, req stays 0 regardless of inputs. There are no nested exceptions.

## Timing
- `cp0_out`, `req`, `epc_out`: zero-cycle combinational paths from state and inputs.
- State updates take effect at the next rising edge.
- `mfc0` in the cycle after `mtc0` returns the new value. There is no same-cycle bypass; the hazard unit stalls if needed.
- Reset values: SR=0, Cause=0, EPC=0, Count=0. Therefore `cp0_out`=0, `epc_out`=0, `req`=0.
- Reset asserted mid-operation clears EXL and pending state asynchronously. `req` drops in the same cycle.
- `hw_int` changes are visible in Cause.IP one edge later. They affect `req` in the same cycle through the live `hw_int` input.

## Configuration
- `CP0_COUNT_EN` defined: adds Count (reg 9), a 32-bit free-running counter.
  - Increments every cycle and wraps 0xFFFFFFFF -> 0.
  - An accepted `mtc0` write loads `cp0_in` and overrides that cycle's increment.
  - Reset clears it to 0.
- `CP0_COUNT_EN` undefined: reg 9 reads 0, writes are ignored, and no counter flops are synthesized.

## Test plan
- Reset, then `exc_code_in`=4, `vpc`=0x3008, `bd_in`=0 -> `req`=1; next cycle SR.EXL=1, Cause=0x0000_0010, EPC=0x3008, `req`=0.
- SR=0x0000_0401 via `mtc0`, `hw_int`=6'b000001, `bd_in`=1, `vpc`=0x3010 -> `req`=1; next cycle EPC=0x300C, Cause.BD=1, ExcCode=0, IP=0x01.
- Same cycle: `hw_int` enabled, `exc_code_in`=12, `we`=1 to EPC with 0xDEAD -> interrupt wins: ExcCode=0, EPC=`vpc`, write dropped.
- EXL=1 with `exl_clr`=1 and `hw_int` pending -> `req`=0 that cycle; EXL=0 next cycle; `req`=1 on the following cycle.
- `mtc0` Cause=0xFFFF_FFFF -> Cause unchanged; `mtc0` SR=0xFFFF_FFFF -> read back 0x0000_FC03.
- With `CP0_COUNT_EN`: write Count=0xFFFF_FFFE; read back 0xFFFF_FFFF one cycle later, then 0x0000_0000 the next. Assert reset mid-count -> 0 immediately.
